keccak_absorb_packer: RTL and testbench

//  Downstream consumer of the 64-bit lane FIFO. Pops message lanes and applies SHA-3 multi-rate padding.

---
 rtl/keccak_absorb_packer_pkg.sv | 27 ++
 rtl/keccak_absorb_packer_if.sv | 28 ++
 rtl/keccak_absorb_packer_pad_lane.sv | 32 +++
 rtl/keccak_absorb_packer.sv | 174 +++++++++++++++++
 tb/tb_keccak_absorb_packer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_absorb_packer_pkg.sv
// Shared constants and FSM encoding for the Keccak absorb packer.
// Configuration macro: KECCAK_SHAKE_PAD_EN selects the SHAKE domain
// separator (8'h1F) instead of the SHA-3 one (8'h06).
package keccak_absorb_packer_pkg;

  localparam int LANE_W_DEF     = 64;
  localparam int RATE_LANES_DEF = 17;
  localparam int LEN_W_DEF      = 16;

  localparam logic [7:0] PAD_SHA3  = 8'h06;
  localparam logic [7:0] PAD_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_LAST  = 8'h80;

`ifdef KECCAK_SHAKE_PAD_EN
  localparam logic [7:0] PAD_DS = PAD_SHAKE;
`else
  localparam logic [7:0] PAD_DS = PAD_SHA3;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PAD   = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

endpackage

// File: rtl/keccak_absorb_packer_if.sv
// Bus bundle between the packer, its lane FIFO and the absorb stage.
// master = packer side, slave = environment (FIFO, control, absorb stage).
interface keccak_absorb_packer_if #(
  parameter int LANE_W     = 64,
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
);
  logic                         start;
  logic [LEN_W-1:0]             msg_bytes;
  logic                         fifo_empty;
  logic [LANE_W-1:0]            fifo_dout;
  logic                         fifo_rd_en;
  logic [RATE_LANES*LANE_W-1:0] blk_data;
  logic                         blk_valid;
  logic                         blk_ready;
  logic                         blk_last;
  logic                         busy;

  modport master (
    input  start, msg_bytes, fifo_empty, fifo_dout, blk_ready,
    output fifo_rd_en, blk_data, blk_valid, blk_last, busy
  );

  modport slave (
    output start, msg_bytes, fifo_empty, fifo_dout, blk_ready,
    input  fifo_rd_en, blk_data, blk_valid, blk_last, busy
  );
endinterface

// File: rtl/keccak_absorb_packer_pad_lane.sv
// Combinational lane padder: when pad_first is set, bytes tail..7 are zeroed
// and the domain separator is XORed into byte[tail] (tail==0 turns a blank
// lane into a pure separator lane); pad_last XORs 8'h80 into byte 7.
module keccak_pad_lane
  import keccak_absorb_packer_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [LANE_W-1:0] lane,
  input  logic [2:0]        tail,
  input  logic              pad_first,
  input  logic              pad_last,
  output logic [LANE_W-1:0] lane_padded
);
  localparam int NB = LANE_W / 8;

  logic [7:0] ds_byte_s;
  logic [7:0] last_byte_s;

  assign ds_byte_s   = pad_first ? PAD_DS : 8'h00;
  assign last_byte_s = pad_last ? PAD_LAST : 8'h00;

  // Mask the unused tail bytes, then fold both pad bytes in (they OR together on byte 7)
  always_comb begin
    lane_padded = lane;
    for (int k = 0; k < NB; k++) begin
      lane_padded[8*k +: 8] = (pad_first && (k >= int'(tail))) ? 8'h00 : lane[8*k +: 8];
    end
    lane_padded[8*int'(tail) +: 8] = lane_padded[8*int'(tail) +: 8] ^ ds_byte_s;
    lane_padded[LANE_W-1 -: 8]     = lane_padded[LANE_W-1 -: 8] ^ last_byte_s;
  end
endmodule

// File: rtl/keccak_absorb_packer.sv
// Keccak absorb packer: pops message lanes from the lane FIFO, packs them
// into RATE_LANES-lane rate blocks, applies SHA-3 multi-rate padding and
// hands blocks to the absorb stage over a valid/ready handshake.
// Configuration macro: KECCAK_SHAKE_PAD_EN (SHAKE domain separator).
module keccak_absorb_packer
  import keccak_absorb_packer_pkg::*;
#(
  parameter int LANE_W     = LANE_W_DEF,
  parameter int RATE_LANES = RATE_LANES_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  keccak_absorb_packer_if.master bus
);
  // Lane counters must hold ceil((2^LEN_W - 1) / 8).
  localparam int CNT_W  = LEN_W - 2;
  localparam int SLOT_W = $clog2(RATE_LANES + 1);
  localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(RATE_LANES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(RATE_LANES - 1);

  state_e              state_r, state_s;
  logic [LANE_W-1:0]   buf_r [RATE_LANES];
  logic [CNT_W-1:0]    need_r, issued_r, captured_r;
  logic [2:0]          tail_r;
  logic [SLOT_W-1:0]   slot_r, slot_iss_r;
  logic                pending_r;
  logic                last_r;

  logic [CNT_W-1:0]    need_s;
  logic                rd_en_s, done_s, full_s, hs_s, start_acc_s;
  logic [SLOT_W-1:0]   pad_idx_s;
  logic                pad_on_last_s;
  logic [LANE_W-1:0]   pad_ds_lane_s, pad_end_lane_s;

  assign need_s        = CNT_W'(bus.msg_bytes[LEN_W-1:3]) + CNT_W'(|bus.msg_bytes[2:0]);
  assign start_acc_s   = (state_r == ST_IDLE) && bus.start;
  assign rd_en_s       = (state_r == ST_FETCH) && !bus.fifo_empty &&
                         (issued_r < need_r) && (slot_iss_r < SLOT_FULL);
  assign done_s        = (captured_r == need_r);
  assign full_s        = (slot_r == SLOT_FULL);
  assign hs_s          = (state_r == ST_EMIT) && bus.blk_ready;
  // A tail lane is already in the buffer; otherwise the separator goes in a fresh slot.
  assign pad_idx_s     = (tail_r != 3'd0) ? (slot_r - SLOT_W'(1)) : slot_r;
  assign pad_on_last_s = (pad_idx_s == SLOT_LAST);

  keccak_pad_lane #(.LANE_W(LANE_W)) u_pad_ds (
    .lane        (buf_r[pad_idx_s]),
    .tail        (tail_r),
    .pad_first   (1'b1),
    .pad_last    (pad_on_last_s),
    .lane_padded (pad_ds_lane_s)
  );

  keccak_pad_lane #(.LANE_W(LANE_W)) u_pad_end (
    .lane        (buf_r[RATE_LANES-1]),
    .tail        (tail_r),
    .pad_first   (1'b0),
    .pad_last    (1'b1),
    .lane_padded (pad_end_lane_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // A tail==0 message that exactly fills the block needs one more, pad-only block.
        if (done_s && (!full_s || (tail_r != 3'd0))) begin
          state_s = ST_PAD;
        end else if (full_s) begin
          state_s = ST_EMIT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_PAD: begin
        state_s = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.blk_ready) begin
          state_s = last_r ? ST_IDLE : ST_FETCH;
        end else begin
          state_s = ST_EMIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Lane counters, read-pending flag and block buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      need_r     <= '0;
      issued_r   <= '0;
      captured_r <= '0;
      tail_r     <= 3'd0;
      slot_r     <= '0;
      slot_iss_r <= '0;
      pending_r  <= 1'b0;
      last_r     <= 1'b0;
      for (int i = 0; i < RATE_LANES; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      pending_r <= rd_en_s;
      if (start_acc_s) begin
        need_r     <= need_s;
        tail_r     <= bus.msg_bytes[2:0];
        issued_r   <= '0;
        captured_r <= '0;
        slot_r     <= '0;
        slot_iss_r <= '0;
        last_r     <= 1'b0;
        for (int i = 0; i < RATE_LANES; i++) begin
          buf_r[i] <= '0;
        end
      end else begin
        if (rd_en_s) begin
          issued_r   <= issued_r + CNT_W'(1);
          slot_iss_r <= slot_iss_r + SLOT_W'(1);
        end
        if (pending_r) begin
          buf_r[slot_r] <= bus.fifo_dout;
          slot_r        <= slot_r + SLOT_W'(1);
          captured_r    <= captured_r + CNT_W'(1);
        end
        if (state_r == ST_PAD) begin
          buf_r[pad_idx_s] <= pad_ds_lane_s;
          if (!pad_on_last_s) begin
            buf_r[RATE_LANES-1] <= pad_end_lane_s;
          end
          last_r <= 1'b1;
        end
        if (hs_s) begin
          slot_r     <= '0;
          slot_iss_r <= '0;
          last_r     <= 1'b0;
          for (int i = 0; i < RATE_LANES; i++) begin
            buf_r[i] <= '0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < RATE_LANES; g++) begin : g_flat
    assign bus.blk_data[g*LANE_W +: LANE_W] = buf_r[g];
  end

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.blk_valid  = (state_r == ST_EMIT);
  assign bus.blk_last   = (state_r == ST_EMIT) && last_r;
  assign bus.busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_keccak_absorb_packer.sv
// Scoreboard bench for keccak_absorb_packer: a byte-level SHA-3 pad10*1
// reference model pushes expected blocks; a monitor pops and compares them
// at each blk_valid/blk_ready handshake.
module tb_keccak_absorb_packer;
  localparam int BLK_W    = 17 * 64;
  localparam int RATE_B   = 136;
`ifdef KECCAK_SHAKE_PAD_EN
  localparam logic [7:0] DS_TB = 8'h1F;
`else
  localparam logic [7:0] DS_TB = 8'h06;
`endif

  typedef struct {
    logic [BLK_W-1:0] data;
    logic             last;
  } blk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keccak_absorb_packer_if #(.LANE_W(64), .RATE_LANES(17), .LEN_W(16)) bus ();

  keccak_absorb_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          passes = 0;
  int          pop_count = 0;
  int          ready_mode = 0;
  logic [63:0] fq[$];
  blk_t        exp_q[$];
  bit          pop_now;
  bit          stalled = 1'b0;
  logic [BLK_W-1:0] held_data;
  logic        held_last;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
  endtask

  function automatic logic [63:0] lane_of(input logic [BLK_W-1:0] b, input int i);
    return b[64*i +: 64];
  endfunction

  // Reference: byte string M || DS || 0* with 0x80 OR'd into the final byte, cut into 136-byte blocks.
  task automatic expect_msg(input logic [63:0] lanes[$], input int len);
    logic [7:0]       p[$];
    logic [63:0]      w;
    logic [BLK_W-1:0] blk;
    blk_t             e;
    int               nblk;
    for (int i = 0; i < len; i++) begin
      w = lanes[i/8];
      p.push_back(w[8*(i%8) +: 8]);
    end
    p.push_back(DS_TB);
    while ((p.size() % RATE_B) != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / RATE_B;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < RATE_B; j++) blk[8*j +: 8] = p[b*RATE_B + j];
      e.data = blk;
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  // FIFO model: empty updated after negedge, pop decided just before posedge, data shortly after it
  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = 64'd0;
    forever begin
      @(negedge clk); #1;
      bus.fifo_empty = (fq.size() == 0);
      #3;
      pop_now = bus.fifo_rd_en && !bus.fifo_empty;
      @(posedge clk); #1;
      if (pop_now) begin
        bus.fifo_dout = fq.pop_front();
        pop_count++;
      end
    end
  end

  // Downstream ready driver: 0 = always ready, 1 = random, 2 = held low
  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.blk_ready = 1'b1;
        1:       bus.blk_ready = ($urandom_range(0, 3) != 0);
        default: bus.blk_ready = 1'b0;
      endcase
    end
  end

  // Monitor: stability while stalled, scoreboard compare on handshake
  initial begin
    blk_t e;
    forever begin
      @(negedge clk); #2;
      if (stalled) begin
        chk("stall_valid", 0, 64'(bus.blk_valid), 64'd1);
        chk("stall_last", 0, 64'(bus.blk_last), 64'(held_last));
        for (int i = 0; i < 17; i++) chk("stall_lane", i, lane_of(bus.blk_data, i), lane_of(held_data, i));
      end
      stalled = 1'b0;
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_block: got block with last=%0b, expected none", bus.blk_last);
        end else begin
          e = exp_q.pop_front();
          chk("blk_last", 0, 64'(bus.blk_last), 64'(e.last));
          for (int i = 0; i < 17; i++) chk("blk_lane", i, lane_of(bus.blk_data, i), lane_of(e.data, i));
        end
      end else if (bus.blk_valid) begin
        held_data = bus.blk_data;
        held_last = bus.blk_last;
        stalled   = 1'b1;
      end
    end
  end

  task automatic pulse_start(input int len);
    @(negedge clk);
    bus.msg_bytes = 16'(len);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.msg_bytes = 16'($urandom);
  endtask

  task automatic wait_done(input int nl);
    int cyc = 0;
    while ((bus.busy || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk); #3;
      cyc++;
    end
    chk("done_in_time", 0, 64'(cyc < 4000), 64'd1);
    chk("pop_count", 0, 64'(pop_count), 64'(nl));
    chk("blocks_left", 0, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_lanes(input logic [63:0] lanes[$], input int len, input int rm, input bit poke);
    expect_msg(lanes, len);
    pop_count  = 0;
    ready_mode = rm;
    foreach (lanes[i]) fq.push_back(lanes[i]);
    pulse_start(len);
    if (poke) begin
      repeat (3) @(negedge clk);
      bus.msg_bytes = 16'd5;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
    end
    wait_done((len + 7) / 8);
  endtask

  task automatic run_rand(input int len, input int rm, input bit poke);
    logic [63:0] lanes[$];
    for (int i = 0; i < (len + 7) / 8; i++) lanes.push_back({$urandom, $urandom});
    run_lanes(lanes, len, rm, poke);
  endtask

  initial begin
    logic [63:0] lanes[$];
    int          cyc;
    int          len;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.msg_bytes = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 0, 64'(bus.blk_valid), 64'd0);
    chk("rst_last", 0, 64'(bus.blk_last), 64'd0);
    chk("rst_busy", 0, 64'(bus.busy), 64'd0);
    chk("rst_rd_en", 0, 64'(bus.fifo_rd_en), 64'd0);
    for (int i = 0; i < 17; i++) chk("rst_lane", i, lane_of(bus.blk_data, i), 64'd0);
    rst = 1'b0;

    // Empty message, 3-byte message with garbage above the tail, 135 and 136 bytes
    run_rand(0, 0, 1'b0);
    lanes = {64'hFFFF_FFFF_FFAA_BBCC};
    run_lanes(lanes, 3, 0, 1'b0);
    run_rand(135, 0, 1'b0);
    run_rand(136, 0, 1'b0);

    // FIFO runs dry mid-block, then the block is back-pressured for 5 cycles
    lanes.delete();
    for (int i = 0; i < 25; i++) lanes.push_back({$urandom, $urandom});
    expect_msg(lanes, 200);
    pop_count  = 0;
    ready_mode = 2;
    for (int i = 0; i < 6; i++) fq.push_back(lanes[i]);
    pulse_start(200);
    repeat (20) @(negedge clk);
    for (int i = 6; i < 25; i++) fq.push_back(lanes[i]);
    cyc = 0;
    while (!bus.blk_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_block_seen", 0, 64'(cyc < 200), 64'd1);
    repeat (5) @(negedge clk);
    ready_mode = 0;
    wait_done(25);

    // Reset in the middle of FETCH with pops in flight
    for (int i = 0; i < 20; i++) fq.push_back({$urandom, $urandom});
    pulse_start(160);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 0, 64'(bus.blk_valid), 64'd0);
    chk("midrst_busy", 0, 64'(bus.busy), 64'd0);
    chk("midrst_rd_en", 0, 64'(bus.fifo_rd_en), 64'd0);
    chk("midrst_last", 0, 64'(bus.blk_last), 64'd0);
    for (int i = 0; i < 17; i++) chk("midrst_lane", i, lane_of(bus.blk_data, i), 64'd0);
    fq.delete();
    @(negedge clk);
    rst = 1'b0;
    run_rand(77, 0, 1'b0);

    // Randomized lengths with random back-pressure and dropped start pulses
    for (int n = 0; n < 10; n++) begin
      len = $urandom_range(0, 420);
      run_rand(len, 1, (len >= 100) && (n % 2 == 0));
    end
    run_rand(272, 1, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
